riscv_dift_ex_tag_unit: RTL and testbench
=========================================

Name: riscv_dift_ex_tag_unit

Overview:
- Parametrised next-generation DIFT tag datapath for the RI5CY EX stage; replaces single-bit tag handling with TAG_WIDTH-bit tags.
- Propagates operand tags to the regfile, store, PC and load paths per a mode code.
- Checks tags against a policy mask and holds a trap request until the controller acknowledges it.
- Keeps a saturating count of violations; sits beside the ALU and is controlled by the EX valid/ready handshake.

Parameters:
TAG_WIDTH, 4, width of every tag
MODE_WIDTH, 3, width of propagation mode code
CNT_WIDTH, 8, width of violation counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ex_valid_i  in  1  EX instruction completes this cycle
wb_ready_i  in  1  WB accepts data
mode_i  in  MODE_WIDTH  propagation mode
tag_a_i  in  TAG_WIDTH  rs1 tag
tag_b_i  in  TAG_WIDTH  rs2 tag
tag_c_i  in  TAG_WIDTH  jump target tag
set_tag_i  in  TAG_WIDTH  value forced by tag-set instruction
register_set_i  in  1  tag-set instruction
regfile_alu_we_i  in  1  ALU writes regfile
regfile_we_i  in  1  load in EX
data_we_i  in  1  store in EX
branch_taken_i  in  1  branch/jump taken
check_s1_i, check_s2_i, check_d_i  in  1 each  check enables
check_mask_i  in  TAG_WIDTH  policy mask
trap_ack_i  in  1  controller accepted trap
clr_count_i  in  1  clear violation counter
rf_wdata_tag_o  out  TAG_WIDTH  regfile write tag (comb)
rf_we_tag_o  out  1  regfile tag write enable (comb)
data_wdata_tag_o  out  TAG_WIDTH  store tag (comb)
data_we_tag_o  out  1  store tag write enable (comb)
pc_tag_o  out  TAG_WIDTH  current PC tag (reg)
wb_rs1_tag_o  out  TAG_WIDTH  load address tag for WB (reg)
wb_rs1_tag_valid_o  out  1  wb_rs1_tag_o valid (reg)
exc_pending_o  out  1  trap request (reg)
exc_src_o  out  3  {d,s2,s1} cause of pending trap (reg)
tag_stall_o  out  1  equals exc_pending_o
exc_count_o  out  CNT_WIDTH  saturating violation count (reg)

Behaviour:
- Reset (rst_n=0 at clk edge): all registered outputs 0; FSM IDLE. Reset mid-PEND drops the trap.
- Result tag res by mode_i:
  - 0 OR a|b; 1 AND a&b; 2 PASS_A a; 3 PASS_B b; 4 CLEAR 0; 5 KEEP a|b; 6 XOR a^b; 7 treated as 0.
  - en=1 for all modes except KEEP; pc_en=1 for modes 0,1,2,3,6.
- Regfile: register_set_i -> rf_wdata_tag_o=set_tag_i, rf_we_tag_o=1. Else rf_wdata_tag_o=res, rf_we_tag_o=en&regfile_alu_we_i.
- Store: data_wdata_tag_o=res; data_we_tag_o=data_we_i&en.
- PC tag: updates only on ex_valid_i&branch_taken_i.
  - tag_c_i!=0 -> pc_tag<=tag_c_i.
  - else if pc_en -> pc_tag<=res.
  - else hold. Not taken -> hold.
- Load tag: on ex_valid_i&regfile_we_i, wb_rs1_tag_o<=tag_a_i and valid<=1. Else if wb_ready_i, valid<=0. Else hold.
- Violation viol, sampled only when ex_valid_i:
  - s1 = check_s1_i & |(tag_a_i&check_mask_i)
  - s2 = check_s2_i & |(tag_b_i&check_mask_i)
  - d = check_d_i & ~regfile_we_i & |(res&check_mask_i); dest check is suppressed for loads.
  - viol = s1|s2|d.
- FSM:
  - IDLE: viol -> PEND, capture exc_src_o={d,s2,s1}; exc_pending_o=1 from next cycle (1-cycle latency).
  - PEND: trap_ack_i & ~viol -> IDLE, src<=0. trap_ack_i & viol -> stay PEND, capture new src. ~trap_ack_i -> hold src; new viol not captured.
  - trap_ack_i in IDLE is ignored.
- Counter: +1 per viol (either state), saturates at 2^CNT_WIDTH-1. clr_count_i -> 0; clr with same-cycle viol -> 1.
- ex_valid_i=0 freezes PC tag, load capture, counter increment and FSM entry. Ack and clear still act.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with trap pending -> all outputs 0, FSM IDLE, exc_count_o=0.
- Propagation, TAG_WIDTH=4: mode 0 with a=4'b0011, b=4'b0100, regfile_alu_we_i=1 -> rf_wdata_tag_o=4'b0111, rf_we_tag_o=1. Mode 5 -> rf_we_tag_o=0. Mode 5 with register_set_i=1, set_tag_i=4'hA -> rf_wdata_tag_o=4'hA, rf_we_tag_o=1.
- Branch:
  - taken, c=0, mode 1, a=4'hF, b=4'h3, ex_valid_i=1 -> pc_tag_o=4'h3 next cycle.
  - next: taken, c=4'h8 -> pc_tag_o=4'h8.
  - not taken -> pc_tag_o stays 4'h8.
- Trap handshake: mask=4'h1, check_s1_i=1, a=4'h1, ex_valid_i=1 -> exc_pending_o=1 and exc_src_o=3'b001 next cycle. Hold ack low 3 cycles -> unchanged. Ack plus simultaneous d-violation -> stays PEND, exc_src_o=3'b100. Ack alone -> IDLE.
- Load suppression: check_d_i=1, regfile_we_i=1, res matches mask -> no violation; wb_rs1_tag_o=tag_a_i and valid=1. Next cycle wb_ready_i=1, ex_valid_i=0 -> valid=0.
- Counter, CNT_WIDTH=2: 5 consecutive violations -> exc_count_o saturates at 3. clr_count_i with simultaneous violation -> 1.

Source files
------------

// File: rtl/riscv_dift_ex_tag_unit.sv
// DIFT tag datapath for the RI5CY EX stage: TAG_WIDTH-bit tag propagation, policy check, trap request, violation count.
// Latency: regfile/store tag outputs are combinational; PC tag, WB load tag, trap request and counter update one cycle after the EX edge.
// Backpressure: no internal stall; ex_valid_i qualifies every state update and tag_stall_o holds the pipeline while a trap is pending.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ex_valid_i, wb_ready_i          EX completion / WB acceptance handshake
//   mode_i, tag_a/b/c_i, set_tag_i  propagation mode, operand/jump tags, tag-set value
//   register_set_i, regfile_alu_we_i, regfile_we_i, data_we_i, branch_taken_i  EX instruction class
//   check_s1/s2/d_i, check_mask_i   policy enables and mask
//   trap_ack_i, clr_count_i         controller trap acknowledge, counter clear
//   rf_*_tag_o, data_*_tag_o        combinational regfile/store tag writes
//   pc_tag_o, wb_rs1_tag_o/_valid_o registered PC tag and load-address tag for WB
//   exc_pending_o, exc_src_o, tag_stall_o, exc_count_o  trap state and violation count
module riscv_dift_ex_tag_unit #(
  parameter int TAG_WIDTH  = 4,
  parameter int MODE_WIDTH = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic                  wb_ready_i,
  input  logic [MODE_WIDTH-1:0] mode_i,
  input  logic [TAG_WIDTH-1:0]  tag_a_i,
  input  logic [TAG_WIDTH-1:0]  tag_b_i,
  input  logic [TAG_WIDTH-1:0]  tag_c_i,
  input  logic [TAG_WIDTH-1:0]  set_tag_i,
  input  logic                  register_set_i,
  input  logic                  regfile_alu_we_i,
  input  logic                  regfile_we_i,
  input  logic                  data_we_i,
  input  logic                  branch_taken_i,
  input  logic                  check_s1_i,
  input  logic                  check_s2_i,
  input  logic                  check_d_i,
  input  logic [TAG_WIDTH-1:0]  check_mask_i,
  input  logic                  trap_ack_i,
  input  logic                  clr_count_i,
  output logic [TAG_WIDTH-1:0]  rf_wdata_tag_o,
  output logic                  rf_we_tag_o,
  output logic [TAG_WIDTH-1:0]  data_wdata_tag_o,
  output logic                  data_we_tag_o,
  output logic [TAG_WIDTH-1:0]  pc_tag_o,
  output logic [TAG_WIDTH-1:0]  wb_rs1_tag_o,
  output logic                  wb_rs1_tag_valid_o,
  output logic                  exc_pending_o,
  output logic [2:0]            exc_src_o,
  output logic                  tag_stall_o,
  output logic [CNT_WIDTH-1:0]  exc_count_o
);

  localparam logic [MODE_WIDTH-1:0] MODE_OR    = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] MODE_AND   = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_PASSA = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0] MODE_PASSB = MODE_WIDTH'(3);
  localparam logic [MODE_WIDTH-1:0] MODE_CLEAR = MODE_WIDTH'(4);
  localparam logic [MODE_WIDTH-1:0] MODE_KEEP  = MODE_WIDTH'(5);
  localparam logic [MODE_WIDTH-1:0] MODE_XOR   = MODE_WIDTH'(6);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

  typedef enum logic {IDLE, PEND} state_t;

  state_t               state;
  logic [TAG_WIDTH-1:0] res;
  logic                 en;
  logic                 pc_en;
  logic                 viol_s1;
  logic                 viol_s2;
  logic                 viol_d;
  logic [2:0]           viol_src;
  logic                 viol;

  // Result tag and enables. KEEP computes a|b for the store data path but
  // never writes it; unlisted codes (7 and up) behave as CLEAR.
  always_comb begin
    res   = '0;
    en    = 1'b1;
    pc_en = 1'b0;
    case (mode_i)
      MODE_OR:    begin res = tag_a_i | tag_b_i; pc_en = 1'b1; end
      MODE_AND:   begin res = tag_a_i & tag_b_i; pc_en = 1'b1; end
      MODE_PASSA: begin res = tag_a_i;           pc_en = 1'b1; end
      MODE_PASSB: begin res = tag_b_i;           pc_en = 1'b1; end
      MODE_CLEAR: res = '0;
      MODE_KEEP:  begin res = tag_a_i | tag_b_i; en = 1'b0; end
      MODE_XOR:   begin res = tag_a_i ^ tag_b_i; pc_en = 1'b1; end
      default:    res = '0;
    endcase
  end

  // Tag-set instructions override the propagated result unconditionally.
  assign rf_wdata_tag_o   = register_set_i ? set_tag_i : res;
  assign rf_we_tag_o      = register_set_i | (en & regfile_alu_we_i);
  assign data_wdata_tag_o = res;
  assign data_we_tag_o    = data_we_i & en;

  // Destination check is skipped for loads: the loaded value's tag is not known yet.
  assign viol_s1  = ex_valid_i & check_s1_i & (|(tag_a_i & check_mask_i));
  assign viol_s2  = ex_valid_i & check_s2_i & (|(tag_b_i & check_mask_i));
  assign viol_d   = ex_valid_i & check_d_i & ~regfile_we_i & (|(res & check_mask_i));
  assign viol_src = {viol_d, viol_s2, viol_s1};
  assign viol     = |viol_src;

  assign tag_stall_o = exc_pending_o;

  // PC tag: an explicit jump-target tag wins over the propagated result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_tag_o <= '0;
    end else if (ex_valid_i && branch_taken_i) begin
      if (tag_c_i != '0)  pc_tag_o <= tag_c_i;
      else if (pc_en)     pc_tag_o <= res;
    end
  end

  // Load address tag handed to WB; a new load overrides a pending drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_rs1_tag_o       <= '0;
      wb_rs1_tag_valid_o <= 1'b0;
    end else if (ex_valid_i && regfile_we_i) begin
      wb_rs1_tag_o       <= tag_a_i;
      wb_rs1_tag_valid_o <= 1'b1;
    end else if (wb_ready_i) begin
      wb_rs1_tag_valid_o <= 1'b0;
    end
  end

  // Trap request FSM. While pending, the cause is only refreshed when the
  // controller acknowledges in the same cycle a new violation arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      exc_pending_o <= 1'b0;
      exc_src_o     <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (viol) begin
            state         <= PEND;
            exc_pending_o <= 1'b1;
            exc_src_o     <= viol_src;
          end
        end
        PEND: begin
          if (trap_ack_i) begin
            if (viol) begin
              exc_src_o <= viol_src;
            end else begin
              state         <= IDLE;
              exc_pending_o <= 1'b0;
              exc_src_o     <= 3'b000;
            end
          end
        end
        default: begin
          state         <= IDLE;
          exc_pending_o <= 1'b0;
          exc_src_o     <= 3'b000;
        end
      endcase
    end
  end

  // Saturating violation counter; a clear does not lose a same-cycle violation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exc_count_o <= '0;
    end else if (clr_count_i) begin
      exc_count_o <= viol ? CNT_WIDTH'(1) : '0;
    end else if (viol && (exc_count_o != CNT_MAX)) begin
      exc_count_o <= exc_count_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_riscv_dift_ex_tag_unit.sv
// Directed-vector bench for riscv_dift_ex_tag_unit with a scoreboard queue.
// Each vector is driven after a falling edge; the monitor compares 1 time unit after the next rising edge.
// Comparison covers the combinational outputs for that vector and the registered state after that edge.
module tb_riscv_dift_ex_tag_unit;

  localparam int TW = 4;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic          ex_valid_i, wb_ready_i;
  logic [2:0]    mode_i;
  logic [TW-1:0] tag_a_i, tag_b_i, tag_c_i, set_tag_i, check_mask_i;
  logic          register_set_i, regfile_alu_we_i, regfile_we_i, data_we_i, branch_taken_i;
  logic          check_s1_i, check_s2_i, check_d_i, trap_ack_i, clr_count_i;
  logic [TW-1:0] rf_wdata_tag_o, data_wdata_tag_o, pc_tag_o, wb_rs1_tag_o;
  logic          rf_we_tag_o, data_we_tag_o, wb_rs1_tag_valid_o, exc_pending_o, tag_stall_o;
  logic [2:0]    exc_src_o;
  logic [CW-1:0] exc_count_o;

  riscv_dift_ex_tag_unit #(.TAG_WIDTH(TW), .MODE_WIDTH(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .wb_ready_i(wb_ready_i),
    .mode_i(mode_i), .tag_a_i(tag_a_i), .tag_b_i(tag_b_i), .tag_c_i(tag_c_i),
    .set_tag_i(set_tag_i), .register_set_i(register_set_i),
    .regfile_alu_we_i(regfile_alu_we_i), .regfile_we_i(regfile_we_i),
    .data_we_i(data_we_i), .branch_taken_i(branch_taken_i),
    .check_s1_i(check_s1_i), .check_s2_i(check_s2_i), .check_d_i(check_d_i),
    .check_mask_i(check_mask_i), .trap_ack_i(trap_ack_i), .clr_count_i(clr_count_i),
    .rf_wdata_tag_o(rf_wdata_tag_o), .rf_we_tag_o(rf_we_tag_o),
    .data_wdata_tag_o(data_wdata_tag_o), .data_we_tag_o(data_we_tag_o),
    .pc_tag_o(pc_tag_o), .wb_rs1_tag_o(wb_rs1_tag_o),
    .wb_rs1_tag_valid_o(wb_rs1_tag_valid_o), .exc_pending_o(exc_pending_o),
    .exc_src_o(exc_src_o), .tag_stall_o(tag_stall_o), .exc_count_o(exc_count_o)
  );

  typedef struct {
    string         name;
    logic [TW-1:0] rf;
    logic          rfwe;
    logic [TW-1:0] dw;
    logic          dwe;
    logic [TW-1:0] pc;
    logic [TW-1:0] wb;
    logic          wbv;
    logic          pend;
    logic [2:0]    src;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t e;
  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string fmt(input exp_t x);
    return $sformatf("rf=%h/%b dw=%h/%b pc=%h wb=%h/%b pend=%b src=%b cnt=%0d",
                     x.rf, x.rfwe, x.dw, x.dwe, x.pc, x.wb, x.wbv, x.pend, x.src, x.cnt);
  endfunction

  // Monitor: pops one expectation per rising edge whenever the driver has issued one.
  initial begin
    exp_t w;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        w = q.pop_front();
        a.name = w.name;
        a.rf = rf_wdata_tag_o;  a.rfwe = rf_we_tag_o;
        a.dw = data_wdata_tag_o; a.dwe = data_we_tag_o;
        a.pc = pc_tag_o; a.wb = wb_rs1_tag_o; a.wbv = wb_rs1_tag_valid_o;
        a.pend = exc_pending_o; a.src = exc_src_o; a.cnt = exc_count_o;
        n_vec++;
        if (a.rf !== w.rf || a.rfwe !== w.rfwe || a.dw !== w.dw || a.dwe !== w.dwe ||
            a.pc !== w.pc || a.wb !== w.wb || a.wbv !== w.wbv || a.pend !== w.pend ||
            a.src !== w.src || a.cnt !== w.cnt || tag_stall_o !== w.pend) begin
          n_bad++;
          $display("FAIL %s: got %s stall=%b, want %s", w.name, fmt(a), tag_stall_o, fmt(w));
        end
      end
    end
  end

  // Default stimulus: idle EX, mode OR with zero tags, so comb outputs are zero.
  task automatic idle();
    rst_n = 1'b1; ex_valid_i = 1'b0; wb_ready_i = 1'b0; mode_i = 3'd0;
    tag_a_i = '0; tag_b_i = '0; tag_c_i = '0; set_tag_i = '0; check_mask_i = '0;
    register_set_i = 1'b0; regfile_alu_we_i = 1'b0; regfile_we_i = 1'b0;
    data_we_i = 1'b0; branch_taken_i = 1'b0;
    check_s1_i = 1'b0; check_s2_i = 1'b0; check_d_i = 1'b0;
    trap_ack_i = 1'b0; clr_count_i = 1'b0;
    e.rf = '0; e.rfwe = 1'b0; e.dw = '0; e.dwe = 1'b0;
  endtask

  task automatic zero_regs();
    e.pc = '0; e.wb = '0; e.wbv = 1'b0; e.pend = 1'b0; e.src = 3'b000; e.cnt = '0;
  endtask

  task automatic step(input string nm);
    e.name = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    // Reset
    idle(); rst_n = 1'b0; zero_regs(); step("reset_a");
    idle(); rst_n = 1'b0; step("reset_b");

    // Build up state (trap, PC tag, load tag), then reset it away.
    idle(); ex_valid_i = 1'b1; check_s1_i = 1'b1; check_mask_i = 4'h1; tag_a_i = 4'h1;
    regfile_we_i = 1'b1; branch_taken_i = 1'b1; tag_c_i = 4'h5;
    e.rf = 4'h1; e.dw = 4'h1;
    e.pc = 4'h5; e.wb = 4'h1; e.wbv = 1'b1; e.pend = 1'b1; e.src = 3'b001; e.cnt = 2'd1;
    step("busy_before_reset");
    idle(); rst_n = 1'b0; zero_regs(); step("reset_pend_a");
    idle(); rst_n = 1'b0; step("reset_pend_b");

    // Propagation
    idle(); mode_i = 3'd0; tag_a_i = 4'b0011; tag_b_i = 4'b0100; regfile_alu_we_i = 1'b1;
    e.rf = 4'b0111; e.rfwe = 1'b1; e.dw = 4'b0111; step("prop_or");
    idle(); mode_i = 3'd5; tag_a_i = 4'b0011; tag_b_i = 4'b0100; regfile_alu_we_i = 1'b1;
    data_we_i = 1'b1; e.rf = 4'b0111; e.dw = 4'b0111; step("prop_keep");
    idle(); mode_i = 3'd5; tag_a_i = 4'b0011; tag_b_i = 4'b0100; regfile_alu_we_i = 1'b1;
    register_set_i = 1'b1; set_tag_i = 4'hA;
    e.rf = 4'hA; e.rfwe = 1'b1; e.dw = 4'b0111; step("prop_set");
    idle(); mode_i = 3'd6; tag_a_i = 4'h5; tag_b_i = 4'h3; data_we_i = 1'b1;
    e.rf = 4'h6; e.dw = 4'h6; e.dwe = 1'b1; step("store_xor");

    // Branch / PC tag
    idle(); ex_valid_i = 1'b1; branch_taken_i = 1'b1; mode_i = 3'd1; tag_a_i = 4'hF; tag_b_i = 4'h3;
    e.rf = 4'h3; e.dw = 4'h3; e.pc = 4'h3; step("br_and");
    idle(); ex_valid_i = 1'b1; branch_taken_i = 1'b1; tag_c_i = 4'h8;
    e.pc = 4'h8; step("br_target");
    idle(); ex_valid_i = 1'b1; tag_c_i = 4'h4; mode_i = 3'd2; tag_a_i = 4'h5;
    e.rf = 4'h5; e.dw = 4'h5; step("br_not_taken");
    idle(); ex_valid_i = 1'b1; branch_taken_i = 1'b1; mode_i = 3'd4; tag_a_i = 4'hF;
    step("br_clear_hold");
    idle(); branch_taken_i = 1'b1; tag_c_i = 4'h2; step("br_no_valid");

    // Trap handshake
    idle(); ex_valid_i = 1'b1; check_s1_i = 1'b1; check_mask_i = 4'h1; tag_a_i = 4'h1;
    e.rf = 4'h1; e.dw = 4'h1; e.pend = 1'b1; e.src = 3'b001; e.cnt = 2'd1; step("trap_s1");
    idle(); ex_valid_i = 1'b1; check_s2_i = 1'b1; check_mask_i = 4'h2; tag_b_i = 4'h2;
    e.rf = 4'h2; e.dw = 4'h2; e.cnt = 2'd2; step("hold_new_viol");
    idle(); step("hold_2");
    idle(); step("hold_3");
    idle(); trap_ack_i = 1'b1; ex_valid_i = 1'b1; check_d_i = 1'b1; check_mask_i = 4'h4; tag_a_i = 4'h4;
    e.rf = 4'h4; e.dw = 4'h4; e.src = 3'b100; e.cnt = 2'd3; step("ack_with_d");
    idle(); trap_ack_i = 1'b1; e.pend = 1'b0; e.src = 3'b000; step("ack_release");
    idle(); trap_ack_i = 1'b1; step("ack_in_idle");

    // Load suppression and WB drain
    idle(); ex_valid_i = 1'b1; regfile_we_i = 1'b1; check_d_i = 1'b1; check_mask_i = 4'h4; tag_a_i = 4'h4;
    e.rf = 4'h4; e.dw = 4'h4; e.wb = 4'h4; e.wbv = 1'b1; step("load_no_viol");
    idle(); step("wb_hold");
    idle(); wb_ready_i = 1'b1; e.wbv = 1'b0; step("wb_drain");

    // Counter saturation and clear
    idle(); clr_count_i = 1'b1; e.cnt = 2'd0; step("cnt_clear");
    for (int i = 0; i < 5; i++) begin
      idle(); ex_valid_i = 1'b1; check_s1_i = 1'b1; check_mask_i = 4'h1; tag_a_i = 4'h1;
      e.rf = 4'h1; e.dw = 4'h1; e.pend = 1'b1; e.src = 3'b001;
      e.cnt = (i < 3) ? CW'(i + 1) : 2'd3;
      step($sformatf("cnt_viol_%0d", i));
    end
    idle(); clr_count_i = 1'b1; ex_valid_i = 1'b1; check_s1_i = 1'b1; check_mask_i = 4'h1; tag_a_i = 4'h1;
    e.rf = 4'h1; e.dw = 4'h1; e.cnt = 2'd1; step("cnt_clear_with_viol");
    idle(); trap_ack_i = 1'b1; e.pend = 1'b0; e.src = 3'b000; step("ack_final");
    idle(); check_s1_i = 1'b1; check_mask_i = 4'h1; tag_a_i = 4'h1;
    e.rf = 4'h1; e.dw = 4'h1; step("viol_without_valid");

    idle();
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
